// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data path.
// Data has fixed priority with a streak limit; one outstanding transaction with a watchdog.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT);
    localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [TMO_W-1:0]    TmoLast   = TMO_W'(TIMEOUT - 1);

    typedef enum logic {StIdle, StWaitRsp} state_e;
    typedef enum logic {OwnIf, OwnD} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic              pick_d;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    // IF only wins a contested cycle once data has used up its streak.
    assign pick_d = d_req && !(if_req && (streak_q == StreakMax));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;

        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (if_req || d_req) begin
                        mem_req = 1'b1;
                        if (pick_d) begin
                            mem_we    = d_we;
                            mem_addr  = d_addr;
                            mem_wdata = d_wdata;
                            mem_be    = d_be;
                            d_gnt     = mem_gnt;
                        end else begin
                            mem_addr = if_addr;
                            mem_be   = '1;
                            if_gnt   = mem_gnt;
                        end
                        if (mem_gnt) begin
                            state_d = StWaitRsp;
                            owner_d = pick_d ? OwnD : OwnIf;
                            tmo_d   = '0;
                            if (pick_d && if_req) begin
                                streak_d = (streak_q == StreakMax) ? streak_q
                                                                   : streak_q + 1'b1;
                            end else begin
                                streak_d = '0;
                            end
                        end
                    end
                end
                StWaitRsp: begin
                    tmo_d = tmo_q + 1'b1;
                    if (mem_rvalid) begin
                        rsp_valid = 1'b1;
                        rsp_data  = mem_rdata;
                        state_d   = StIdle;
                        tmo_d     = '0;
                    end else if (tmo_q == TmoLast) begin
                        rsp_valid = 1'b1;
                        rsp_err   = 1'b1;
                        state_d   = StIdle;
                        tmo_d     = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if_rvalid = rsp_valid && (owner_q == OwnIf);
        if_err    = rsp_err && (owner_q == OwnIf);
        if_rdata  = (owner_q == OwnIf) ? rsp_data : '0;
        d_rvalid  = rsp_valid && (owner_q == OwnD);
        d_err     = rsp_err && (owner_q == OwnD);
        d_rdata   = (owner_q == OwnD) ? rsp_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= OwnIf;
            streak_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, every cycle
// checked against a transaction-level model of the arbitration and response rules.
module tb_mem_port_arbiter;

    localparam int MAX = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int errors = 0;
    int checks = 0;
    string phase = "init";

    // Model: busy flag, owner, data-streak length, cycles waited since grant.
    bit m_busy = 0, m_own_d = 0, n_busy, n_own_d;
    int m_streak = 0, m_age = 0, n_streak, n_age;
    bit e_want_d;
    logic [6:0]  e_flags;
    logic [31:0] e_if_rdata, e_d_rdata, e_addr;
    logic        e_we;
    logic [3:0]  e_be;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAX), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called after inputs are driven: predicts this cycle's outputs and checks them.
    task automatic settle();
        bit rv, er;
        logic [31:0] rd;
        #1;
        n_busy = m_busy; n_own_d = m_own_d; n_streak = m_streak; n_age = m_age;
        e_flags = '0; e_if_rdata = '0; e_d_rdata = '0; e_addr = '0; e_we = 0; e_be = '0;
        e_want_d = 0; rv = 0; er = 0; rd = '0;
        if (rst) begin
            n_busy = 0; n_own_d = 0; n_streak = 0; n_age = 0;
        end else if (!m_busy) begin
            if (if_req || d_req) begin
                e_want_d = d_req && !(if_req && m_streak >= MAX);
                e_flags[0] = 1'b1;
                e_we   = e_want_d ? d_we : 1'b0;
                e_addr = e_want_d ? d_addr : if_addr;
                e_be   = e_want_d ? d_be : 4'hf;
                if (mem_gnt) begin
                    if (e_want_d) e_flags[5] = 1'b1; else e_flags[6] = 1'b1;
                    n_busy = 1; n_own_d = e_want_d; n_age = 1;
                    n_streak = (e_want_d && if_req) ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1)
                                                    : 0;
                end
            end
        end else begin
            if (mem_rvalid) begin
                rv = 1; rd = mem_rdata; n_busy = 0;
            end else if (m_age == TMO) begin
                rv = 1; er = 1; n_busy = 0;
            end else begin
                n_age = m_age + 1;
            end
        end
        if (m_own_d) begin
            e_flags[2] = rv; e_flags[1] = er; e_d_rdata = rd;
        end else begin
            e_flags[4] = rv; e_flags[3] = er; e_if_rdata = rd;
        end
        chk({phase, "_flags"}, {if_gnt, d_gnt, if_rvalid, if_err, d_rvalid, d_err, mem_req},
            e_flags);
        chk({phase, "_rdata"}, {if_rdata, d_rdata}, {e_if_rdata, e_d_rdata});
        if (rst) chk({phase, "_rst_mem"}, {mem_we, mem_addr, mem_wdata, mem_be}, 69'd0);
        else if (e_flags[0]) chk({phase, "_mem"}, {mem_we, mem_addr, mem_be}, {e_we, e_addr, e_be});
        if (!rst && e_flags[0] && e_want_d) chk({phase, "_wdata"}, mem_wdata, d_wdata);
    endtask

    task automatic advance();
        m_busy = n_busy; m_own_d = n_own_d; m_streak = n_streak; m_age = n_age;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;
        int ng;
        bit drop_if, drop_d;
        rst = 1; if_req = 0; d_req = 0; d_we = 0; mem_gnt = 0; mem_rvalid = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
        @(negedge clk);

        // Reset with every input active: all outputs must be zero.
        phase = "reset";
        if_req = 1; d_req = 1; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hdeadbeef;
        settle();
        chk("reset_all_zero", {if_gnt, if_rvalid, if_err, if_rdata, d_gnt, d_rvalid, d_err,
            d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be}, '0);
        advance();

        // Fetch only.
        phase = "t1"; rst = 0; d_req = 0; mem_rvalid = 0; if_addr = 32'h100;
        settle();
        chk("t1_if_gnt", {if_gnt, d_gnt, mem_req, mem_addr, mem_be}, {1'b1, 1'b0, 1'b1, 32'h100, 4'hf});
        advance();
        if_req = 0; settle(); advance();
        mem_rvalid = 1; mem_rdata = 32'h00500093; settle();
        chk("t1_rsp", {if_rvalid, if_rdata, if_err, d_rvalid, d_err, d_rdata},
            {1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 32'h0});
        advance();

        // Contested cycle: data store wins, IF follows once d_req is low.
        phase = "t2"; mem_rvalid = 0; if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hcafef00d; d_be = 4'h3;
        settle();
        chk("t2_d_gnt", {d_gnt, if_gnt, mem_we, mem_addr}, {1'b1, 1'b0, 1'b1, 32'h2000});
        advance();
        d_req = 0; mem_rvalid = 1; mem_rdata = 32'h0; settle();
        chk("t2_ack", {d_rvalid, d_err, if_gnt, mem_req}, 4'b1000);
        advance();
        mem_rvalid = 0; settle();
        chk("t2_if_after", {if_gnt, mem_addr}, {1'b1, 32'h104});
        advance();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h13; settle(); advance();

        // Starvation: both held high, memory answers immediately.
        phase = "t3"; if_req = 1; d_req = 1; d_we = 0; mem_gnt = 1; pat = '0; ng = 0;
        for (int i = 0; i < 16; i++) begin
            mem_rvalid = m_busy; mem_rdata = $urandom;
            settle();
            if ((if_gnt || d_gnt) && ng < 6) begin
                pat = {pat[6:0], d_gnt};
                ng++;
            end
            advance();
        end
        chk("t3_grant_order", {ng[7:0], pat}, {8'd6, 8'b00111101});
        if_req = 0; d_req = 0; mem_rvalid = 1; settle(); advance();

        // Timeout on a load.
        phase = "t4"; mem_rvalid = 0; d_req = 1; d_we = 0; d_addr = 32'h3000;
        settle();
        chk("t4_gnt", d_gnt, 1'b1);
        advance();
        d_req = 0;
        for (int i = 1; i < TMO; i++) begin
            settle();
            chk("t4_quiet", {d_rvalid, d_err}, 2'b00);
            advance();
        end
        settle();
        chk("t4_timeout", {d_rvalid, d_err, d_rdata, if_rvalid}, {1'b1, 1'b1, 32'h0, 1'b0});
        advance();
        mem_rvalid = 1; mem_rdata = 32'h5555; settle();
        chk("t4_late_ignored", {if_rvalid, d_rvalid, if_err, d_err, d_rdata, if_rdata}, '0);
        advance();

        // Reset mid-transaction.
        phase = "t5"; mem_rvalid = 0; d_req = 1; settle(); advance();
        d_req = 0; settle(); advance();
        rst = 1; if_req = 1; d_req = 1; mem_rvalid = 1; settle();
        chk("t5_rst_zero", {if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_req, d_rdata}, '0);
        advance();
        rst = 0; if_req = 0; d_req = 0; settle();
        chk("t5_stray", {if_rvalid, d_rvalid, d_err, if_err, d_rdata}, '0);
        advance();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h200; settle();
        chk("t5_regrant", {if_gnt, mem_addr}, {1'b1, 32'h200});
        advance();
        if_req = 0; mem_rvalid = 1; settle(); advance();

        // Memory stalls the grant for three cycles.
        phase = "t6"; mem_rvalid = 0; mem_gnt = 0; if_req = 1; d_req = 1; d_we = 1;
        d_addr = 32'h4040;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t6_stall", {mem_req, mem_addr, if_gnt, d_gnt}, {1'b1, 32'h4040, 2'b00});
            advance();
        end
        mem_gnt = 1; settle();
        chk("t6_gnt", {d_gnt, if_gnt}, 2'b10);
        advance();
        if_req = 0; d_req = 0; mem_rvalid = 1; settle(); advance();

        // Random traffic against the model.
        phase = "rand"; drop_if = 0; drop_d = 0;
        for (int i = 0; i < 600; i++) begin
            if (drop_if) if_req = 0;
            if (drop_d) d_req = 0;
            rst = ($urandom_range(0, 99) == 0);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hffff_fffc;
            end
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom;
                d_wdata = $urandom; d_be = $urandom_range(0, 15);
            end
            mem_gnt = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            settle();
            drop_if = e_flags[6];
            drop_d = e_flags[5];
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
